ipg_tx_slot_sched: RTL

//  TX-side scheduler for in-IPG messaging. Sits between the 64b/66b encoder and the PHY gearbox.

---
 rtl/ipg_tx_slot_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ipg_tx_slot_sched.sv
// In-IPG TX slot scheduler: replaces eligible pure-idle blocks with queued REQ/RESP blocks.
// Optional grant/lost-slot statistics are enabled with IPG_TX_SCHED_STATS_EN.
module ipg_tx_slot_sched #(
    parameter int unsigned GUARD_BLOCKS   = 2,
    parameter int unsigned RESP_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_hdr,
    input  logic [63:0] in_data,
    input  logic        req_valid,
    input  logic [55:0] req_data,
    output logic        req_ready,
    input  logic        resp_valid,
    input  logic [55:0] resp_data,
    output logic        resp_ready,
    output logic [1:0]  out_hdr,
    output logic [63:0] out_data,
    output logic        out_slot
`ifdef IPG_TX_SCHED_STATS_EN
    ,
    output logic [15:0] stat_req_cnt,
    output logic [15:0] stat_resp_cnt,
    output logic [15:0] stat_idle_lost_cnt
`endif
);

    localparam logic [3:0] GUARD_LIM = 4'(GUARD_BLOCKS);
    localparam logic [3:0] BURST_LIM = 4'(RESP_BURST_MAX);
    localparam logic [1:0] HDR_CTRL  = 2'b01;
    localparam logic [1:0] HDR_DATA  = 2'b10;
    localparam logic [7:0] TYPE_IDLE = 8'h1e;
    localparam logic [7:0] TYPE_REQ  = 8'h1a;
    localparam logic [7:0] TYPE_RESP = 8'h1f;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_GUARD = 2'd1,
        S_STEAL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  guard_cnt_q, guard_cnt_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [1:0]  out_hdr_q, out_hdr_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_slot_q, out_slot_d;

    logic is_ctrl, is_idle, is_term, is_start;
    logic eligible, grant_req, grant_resp;

    // Block classification of the current input block
    always_comb begin
        is_ctrl  = (in_hdr == HDR_CTRL);
        is_idle  = is_ctrl && (in_data[7:0] == TYPE_IDLE) && (in_data[63:8] == 56'd0);
        is_term  = 1'b0;
        is_start = 1'b0;
        if (is_ctrl) begin
            case (in_data[7:0])
                8'h87, 8'h99, 8'haa, 8'hb4,
                8'hcc, 8'hd2, 8'he1, 8'hff: is_term  = 1'b1;
                8'h78, 8'h33, 8'h66:        is_start = 1'b1;
                default: ;
            endcase
        end
    end

    // Slot-stealing FSM: a data block always returns to S_DATA
    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        if (in_hdr == HDR_DATA) begin
            state_d = S_DATA;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (is_term) begin
                        guard_cnt_d = 4'd0;
                        state_d     = (GUARD_LIM == 4'd0) ? S_STEAL : S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (is_start) begin
                        state_d = S_DATA;
                    end else if (is_idle) begin
                        guard_cnt_d = guard_cnt_q + 4'd1;
                        if ((guard_cnt_q + 4'd1) == GUARD_LIM) begin
                            state_d = S_STEAL;
                        end
                    end
                end
                S_STEAL: begin
                    if (is_start) begin
                        state_d = S_DATA;
                    end
                end
                default: state_d = S_DATA;
            endcase
        end
    end

    // Arbitration: RESP first, one REQ forced after a full RESP burst
    always_comb begin
        eligible    = is_idle && (state_q == S_STEAL);
        grant_req   = eligible && req_valid && (!resp_valid || (burst_cnt_q == BURST_LIM));
        grant_resp  = eligible && resp_valid && !grant_req;
        burst_cnt_d = burst_cnt_q;
        if (!req_valid || grant_req) begin
            burst_cnt_d = 4'd0;
        end else if (grant_resp && (burst_cnt_q != BURST_LIM)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    // Output block selection
    always_comb begin
        out_hdr_d  = in_hdr;
        out_data_d = in_data;
        out_slot_d = 1'b0;
        if (grant_req) begin
            out_hdr_d  = HDR_CTRL;
            out_data_d = {req_data, TYPE_REQ};
            out_slot_d = 1'b1;
        end else if (grant_resp) begin
            out_hdr_d  = HDR_CTRL;
            out_data_d = {resp_data, TYPE_RESP};
            out_slot_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DATA;
            guard_cnt_q <= 4'd0;
            burst_cnt_q <= 4'd0;
            out_hdr_q   <= HDR_CTRL;
            out_data_q  <= 64'(TYPE_IDLE);
            out_slot_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            out_hdr_q   <= out_hdr_d;
            out_data_q  <= out_data_d;
            out_slot_q  <= out_slot_d;
        end
    end

    assign req_ready  = grant_req && !rst;
    assign resp_ready = grant_resp && !rst;
    assign out_hdr    = out_hdr_q;
    assign out_data   = out_data_q;
    assign out_slot   = out_slot_q;

`ifdef IPG_TX_SCHED_STATS_EN
    logic [15:0] stat_req_cnt_q, stat_req_cnt_d;
    logic [15:0] stat_resp_cnt_q, stat_resp_cnt_d;
    logic [15:0] stat_lost_cnt_q, stat_lost_cnt_d;

    // Saturating grant counters; a lost slot means an eligible idle went unused with work queued
    always_comb begin
        stat_req_cnt_d  = stat_req_cnt_q;
        stat_resp_cnt_d = stat_resp_cnt_q;
        stat_lost_cnt_d = stat_lost_cnt_q;
        if (grant_req && (stat_req_cnt_q != 16'hffff)) begin
            stat_req_cnt_d = stat_req_cnt_q + 16'd1;
        end
        if (grant_resp && (stat_resp_cnt_q != 16'hffff)) begin
            stat_resp_cnt_d = stat_resp_cnt_q + 16'd1;
        end
        if (eligible && (req_valid || resp_valid) && !grant_req && !grant_resp
            && (stat_lost_cnt_q != 16'hffff)) begin
            stat_lost_cnt_d = stat_lost_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt_q  <= 16'd0;
            stat_resp_cnt_q <= 16'd0;
            stat_lost_cnt_q <= 16'd0;
        end else begin
            stat_req_cnt_q  <= stat_req_cnt_d;
            stat_resp_cnt_q <= stat_resp_cnt_d;
            stat_lost_cnt_q <= stat_lost_cnt_d;
        end
    end

    assign stat_req_cnt       = stat_req_cnt_q;
    assign stat_resp_cnt      = stat_resp_cnt_q;
    assign stat_idle_lost_cnt = stat_lost_cnt_q;
`endif

endmodule
